// File: rtl/vote_logger_pkg.sv
// Shared definitions for the voting machine front end.
// Holds the candidate count, default tally width, mode encodings, the
// per-cycle decision encoding and small helpers for the press vector.
package voting_pkg;

    localparam int NUM_CANDIDATES = 4;
    localparam int VOTE_W         = 8;
    localparam int CAND_IDX_W     = $clog2(NUM_CANDIDATES);

    localparam logic MODE_VOTING = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

    // Outcome of one clock's worth of press pulses.
    typedef enum logic [1:0] {
        DECIDE_NONE   = 2'd0,
        DECIDE_ACCEPT = 2'd1,
        DECIDE_REJECT = 2'd2
    } decision_e;

    // True when exactly one candidate pulsed this cycle.
    function automatic logic is_onehot(input logic [NUM_CANDIDATES-1:0] v);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            ones = ones + {31'd0, v[i]};
        end
        return (ones == 32'd1);
    endfunction

    // Index of the single set bit; only meaningful when is_onehot(v).
    function automatic logic [CAND_IDX_W-1:0] onehot_index(input logic [NUM_CANDIDATES-1:0] v);
        logic [CAND_IDX_W-1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/vote_logger_if.sv
// Bundle between the voting front end and its environment.
//  master: drives mode and the raw buttons, observes tallies and status.
//  slave : the vote_logger itself.
//  mode                      voting (0) / result (1)
//  button1..4                raw asynchronous push-buttons
//  candidate1..4_vote        registered tallies
//  candidate1..4_button_press debounced button levels
//  valid_vote_casted         one-cycle pulse per accepted vote
//  vote_rejected             one-cycle pulse per refused press
//  busy                      lockout in progress
interface vote_logger_if #(parameter int VOTE_W = voting_pkg::VOTE_W);

    logic              mode;
    logic              button1;
    logic              button2;
    logic              button3;
    logic              button4;
    logic [VOTE_W-1:0] candidate1_vote;
    logic [VOTE_W-1:0] candidate2_vote;
    logic [VOTE_W-1:0] candidate3_vote;
    logic [VOTE_W-1:0] candidate4_vote;
    logic              candidate1_button_press;
    logic              candidate2_button_press;
    logic              candidate3_button_press;
    logic              candidate4_button_press;
    logic              valid_vote_casted;
    logic              vote_rejected;
    logic              busy;

    modport master (
        output mode, button1, button2, button3, button4,
        input  candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
        input  candidate1_button_press, candidate2_button_press,
        input  candidate3_button_press, candidate4_button_press,
        input  valid_vote_casted, vote_rejected, busy
    );

    modport slave (
        input  mode, button1, button2, button3, button4,
        output candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
        output candidate1_button_press, candidate2_button_press,
        output candidate3_button_press, candidate4_button_press,
        output valid_vote_casted, vote_rejected, busy
    );

endinterface

// File: rtl/vote_logger_button_conditioner.sv
// Conditions one raw push-button: two-flop synchroniser, debounce counter,
// registered rising-edge detector.
//  clock, reset  system clock, async active-low reset
//  button        raw asynchronous input
//  level         debounced level (register)
//  press_pulse   one-clock pulse, registered, one cycle after level rises
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic press_pulse
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1 before the level flips.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             level_q_r;
    logic             pulse_r;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], button};
        end
    end

    // Debounce: any agreement between synced and debounced values restarts
    // the count, so the level moves only after DEBOUNCE_CYCLES of steady mismatch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
        end else if (sync_r[1] != level_r) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= sync_r[1];
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Registered rising-edge detect; a held button yields a single pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q_r <= 1'b0;
            pulse_r   <= 1'b0;
        end else begin
            level_q_r <= level_r;
            pulse_r   <= level_r & ~level_q_r;
        end
    end

    assign level       = level_r;
    assign press_pulse = pulse_r;

endmodule

// File: rtl/vote_logger.sv
// Voting machine front end: conditions four candidate buttons, and in voting
// mode turns each clean single press into one tally increment, guarded by a
// post-vote lockout and tally saturation.
//  clock, reset  system clock, async active-low reset
//  bus (slave)   mode, raw buttons in; tallies, debounced levels,
//                valid_vote_casted / vote_rejected pulses and busy out
module vote_logger #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LOCKOUT_CYCLES  = 100_000_000,
    parameter int VOTE_W          = voting_pkg::VOTE_W
) (
    input  logic          clock,
    input  logic          reset,
    vote_logger_if.slave  bus
);

    import voting_pkg::*;

    localparam int                LOCK_W    = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
    localparam logic [VOTE_W-1:0] TALLY_MAX = {VOTE_W{1'b1}};

    logic [NUM_CANDIDATES-1:0] button_s;
    logic [NUM_CANDIDATES-1:0] level_s;
    logic [NUM_CANDIDATES-1:0] pulse_s;
    logic [CAND_IDX_W-1:0]     target_s;
    decision_e                 decision_s;
    logic [LOCK_W-1:0]         lockout_nxt_s;

    logic [VOTE_W-1:0]         tally_r [NUM_CANDIDATES];
    logic [LOCK_W-1:0]         lockout_r;
    logic                      busy_r;
    logic                      valid_r;
    logic                      reject_r;

    assign button_s = {bus.button4, bus.button3, bus.button2, bus.button1};

    genvar g;
    generate
        for (g = 0; g < NUM_CANDIDATES; g++) begin : g_cond
            button_conditioner #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_cond (
                .clock      (clock),
                .reset      (reset),
                .button     (button_s[g]),
                .level      (level_s[g]),
                .press_pulse(pulse_s[g])
            );
        end
    endgenerate

    // Decide what this cycle's pulses mean and where the lockout goes next.
    always_comb begin
        target_s   = onehot_index(pulse_s);
        decision_s = DECIDE_NONE;
        if (lockout_r != {LOCK_W{1'b0}}) begin
            lockout_nxt_s = lockout_r - LOCK_W'(1);
        end else begin
            lockout_nxt_s = {LOCK_W{1'b0}};
        end

        if (bus.mode == MODE_RESULT) begin
            // Pulses arriving in result mode are dropped silently.
            decision_s = DECIDE_NONE;
        end else if (pulse_s != {NUM_CANDIDATES{1'b0}}) begin
            // Simultaneous presses, an active lockout or a full tally all
            // refuse the press; a refusal never restarts the lockout.
            if (is_onehot(pulse_s) && (lockout_r == {LOCK_W{1'b0}}) &&
                (tally_r[target_s] != TALLY_MAX)) begin
                decision_s    = DECIDE_ACCEPT;
                lockout_nxt_s = LOCK_LOAD;
            end else begin
                decision_s = DECIDE_REJECT;
            end
        end else begin
            decision_s = DECIDE_NONE;
        end
    end

    // Decision register: tallies, status pulses and the lockout counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CANDIDATES; i++) begin
                tally_r[i] <= {VOTE_W{1'b0}};
            end
            lockout_r <= {LOCK_W{1'b0}};
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            reject_r  <= 1'b0;
        end else begin
            lockout_r <= lockout_nxt_s;
            busy_r    <= (lockout_nxt_s != {LOCK_W{1'b0}});
            case (decision_s)
                DECIDE_ACCEPT: begin
                    valid_r  <= 1'b1;
                    reject_r <= 1'b0;
                    for (int i = 0; i < NUM_CANDIDATES; i++) begin
                        if (target_s == CAND_IDX_W'(i)) begin
                            tally_r[i] <= tally_r[i] + VOTE_W'(1);
                        end
                    end
                end
                DECIDE_REJECT: begin
                    valid_r  <= 1'b0;
                    reject_r <= 1'b1;
                end
                default: begin
                    valid_r  <= 1'b0;
                    reject_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.candidate1_vote         = tally_r[0];
    assign bus.candidate2_vote         = tally_r[1];
    assign bus.candidate3_vote         = tally_r[2];
    assign bus.candidate4_vote         = tally_r[3];
    assign bus.candidate1_button_press = level_s[0];
    assign bus.candidate2_button_press = level_s[1];
    assign bus.candidate3_button_press = level_s[2];
    assign bus.candidate4_button_press = level_s[3];
    assign bus.valid_vote_casted       = valid_r;
    assign bus.vote_rejected           = reject_r;
    assign bus.busy                    = busy_r;

endmodule
